seq_multiplier: RTL

//  Multi-cycle shift-add multiplier feeding the HiLo register pair.

---
 rtl/seq_multiplier.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: one multiplier bit per clock, 2*WIDTH-bit product on MulAns.
// Optional two's-complement operands when the SIGNED_MUL_EN macro is defined.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   MulAns
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_r, state_s;
    logic [WIDTH-1:0]     mcand_r, mcand_s;
    logic [AW-1:0]        acc_r, acc_s;
    logic [CW-1:0]        count_r, count_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic [2*WIDTH-1:0]   ans_r, ans_s;
    logic [WIDTH:0]       upper_s;

`ifdef SIGNED_MUL_EN
    logic                 sign_r, sign_s;

    // Magnitude of a two's-complement operand; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] op_mag(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] m;
        if (a[WIDTH-1]) begin
            m = ~a + WIDTH'(1);
        end else begin
            m = a;
        end
        return m;
    endfunction

    // Two's-complement negation of the full-width product.
    function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction
`endif

    // Next-state, datapath and output decode for the shift-add sequence.
    always_comb begin
        state_s = state_r;
        mcand_s = mcand_r;
        acc_s   = acc_r;
        count_s = count_r;
        ans_s   = ans_r;
        upper_s = {(WIDTH+1){1'b0}};
`ifdef SIGNED_MUL_EN
        sign_s  = sign_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
`ifdef SIGNED_MUL_EN
                    mcand_s = op_mag(multiplicand);
                    acc_s   = {{(WIDTH+1){1'b0}}, op_mag(multiplier)};
                    sign_s  = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`else
                    mcand_s = multiplicand;
                    acc_s   = {{(WIDTH+1){1'b0}}, multiplier};
`endif
                    count_s = {CW{1'b0}};
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // The upper half keeps one extra bit so the add carry is never lost.
                if (acc_r[0]) begin
                    upper_s = acc_r[AW-1:WIDTH] + {1'b0, mcand_r};
                end else begin
                    upper_s = acc_r[AW-1:WIDTH];
                end
                acc_s   = {1'b0, upper_s, acc_r[WIDTH-1:1]};
                count_s = count_r + CW'(1);
                if (count_r == CW'(WIDTH - 1)) begin
`ifdef SIGNED_MUL_EN
                    if (sign_r) begin
                        ans_s = negate_wide(acc_s[2*WIDTH-1:0]);
                    end else begin
                        ans_s = acc_s[2*WIDTH-1:0];
                    end
`else
                    ans_s = acc_s[2*WIDTH-1:0];
`endif
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == RUN) || (state_s == DONE);
        done_s = (state_s == DONE);
    end

    // State, datapath and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            mcand_r <= {WIDTH{1'b0}};
            acc_r   <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ans_r   <= {(2*WIDTH){1'b0}};
`ifdef SIGNED_MUL_EN
            sign_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            mcand_r <= mcand_s;
            acc_r   <= acc_s;
            count_r <= count_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ans_r   <= ans_s;
`ifdef SIGNED_MUL_EN
            sign_r  <= sign_s;
`endif
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign MulAns = ans_r;

endmodule
